// File: rtl/fx2_pkg.sv
// Shared constants and types for the FX2 slave-FIFO responder.
package fx2_pkg;

  localparam int unsigned DATA_W             = 16;
  localparam int unsigned DEFAULT_DEPTH_LOG2 = 9;
  localparam int unsigned DEFAULT_PKT_WORDS  = 256;

  localparam logic [1:0] ADDR_EP2 = 2'b00;
  localparam logic [1:0] ADDR_EP6 = 2'b10;

  typedef struct packed {
    logic rd_empty;
    logic wr_full;
    logic addr;
    logic conflict;
  } fx2_err_t;

endpackage

// File: rtl/fx2_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a registered head word that is
// valid in the same cycle the pointers report non-empty.
module fx2_sync_fifo
  import fx2_pkg::*;
#(
  parameter int unsigned DW = DATA_W,
  parameter int unsigned AW = DEFAULT_DEPTH_LOG2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_rd_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_wr_ptr,
  output logic [AW:0]   o_rd_ptr
);

  localparam int unsigned DEPTH   = 2 ** AW;
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [AW:0]   w_wr_ptr_nxt;
  logic [AW:0]   w_rd_ptr_nxt;
  logic [DW-1:0] r_rd_data;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_push       = i_push & ~o_full;
  assign w_pop        = i_pop & ~o_empty;
  assign w_wr_ptr_nxt = w_push ? r_wr_ptr + PTR_ONE : r_wr_ptr;
  assign w_rd_ptr_nxt = w_pop ? r_rd_ptr + PTR_ONE : r_rd_ptr;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  // Head register looks one pop ahead; bypass covers a word landing in the head slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rd_data <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      if (w_push && (w_rd_ptr_nxt[AW-1:0] == r_wr_ptr[AW-1:0])) begin
        r_rd_data <= i_data;
      end else begin
        r_rd_data <= r_mem[w_rd_ptr_nxt[AW-1:0]];
      end
    end
  end

  assign o_rd_data = o_empty ? '0 : r_rd_data;
  assign o_wr_ptr  = r_wr_ptr;
  assign o_rd_ptr  = r_rd_ptr;

endmodule

// File: rtl/fx2_slave_fifo_responder.sv
// FX2-side slave-FIFO responder: EP2 (host -> bus master) and EP6 (bus master -> host)
// with packet commit by PKTEND or auto-commit at PKT_WORDS.
module fx2_slave_fifo_responder
  import fx2_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter int unsigned PKT_WORDS  = DEFAULT_PKT_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fx2_slcs_n,
  input  logic              fx2_slrd_n,
  input  logic              fx2_slwr_n,
  input  logic              fx2_sloe_n,
  input  logic              fx2_pktend_n,
  input  logic [1:0]        fx2_a,
  input  logic [DATA_W-1:0] fx2_db_in,
  output logic [DATA_W-1:0] fx2_db_out,
  output logic              fx2_db_oe,
  output logic              fx2_flaga,
  output logic              fx2_flagb,
  output logic              fx2_flagc,
  output logic              fx2_flagd,
  input  logic              host_wr_valid,
  output logic              host_wr_ready,
  input  logic [DATA_W-1:0] host_wr_data,
  output logic              host_rd_valid,
  input  logic              host_rd_ready,
  output logic [DATA_W-1:0] host_rd_data,
  output logic              host_rd_last,
  output logic              err_rd_empty,
  output logic              err_wr_full,
  output logic              err_addr,
  output logic              err_conflict
);

  localparam int unsigned AW       = DEPTH_LOG2;
  localparam int unsigned DEPTH    = 2 ** AW;
  localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);
  localparam logic [AW:0] PKT_LAST = (AW + 1)'(PKT_WORDS - 1);

  logic w_sel, w_a_ep2, w_a_ep6, w_a_bad;
  logic w_rd, w_oe, w_wr, w_pktend, w_conflict, w_strobe_bad;

  logic              w_ep2_push, w_ep2_pop, w_ep2_full, w_ep2_empty;
  logic [AW:0]       w_ep2_wr_ptr, w_ep2_rd_ptr;
  logic [DATA_W-1:0] w_ep2_data;
  logic              w_unused_ep2;

  logic              w_ep6_push, w_ep6_pop, w_ep6_full, w_ep6_empty;
  logic [AW:0]       w_ep6_wr_ptr, w_ep6_rd_ptr;
  logic [DATA_W-1:0] w_ep6_data;

  logic [AW:0]       r_commit_ptr, w_commit_d, w_unc;
  logic [DEPTH-1:0]  r_last;
  logic              w_last_new, w_set_last_prev;
  logic [AW-1:0]     w_prev_addr;
  fx2_err_t          r_err;

  assign w_sel        = ~fx2_slcs_n;
  assign w_a_ep2      = (fx2_a == ADDR_EP2);
  assign w_a_ep6      = (fx2_a == ADDR_EP6);
  assign w_a_bad      = ~(w_a_ep2 | w_a_ep6);
  assign w_rd         = w_sel & ~fx2_slrd_n & w_a_ep2;
  assign w_oe         = w_sel & ~fx2_sloe_n & w_a_ep2;
  assign w_wr         = w_sel & ~fx2_slwr_n & w_a_ep6;
  assign w_pktend     = w_sel & ~fx2_pktend_n & w_a_ep6;
  assign w_conflict   = w_sel & ~fx2_sloe_n & ~fx2_slwr_n;
  assign w_strobe_bad = w_sel & w_a_bad & (~fx2_slrd_n | ~fx2_slwr_n | ~fx2_pktend_n);

  assign w_ep2_push = host_wr_valid & ~w_ep2_full;
  assign w_ep2_pop  = w_rd & ~w_ep2_empty;

  fx2_sync_fifo #(
    .DW (DATA_W),
    .AW (AW)
  ) u_ep2 (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_ep2_push),
    .i_data    (host_wr_data),
    .i_pop     (w_ep2_pop),
    .o_rd_data (w_ep2_data),
    .o_full    (w_ep2_full),
    .o_empty   (w_ep2_empty),
    .o_wr_ptr  (w_ep2_wr_ptr),
    .o_rd_ptr  (w_ep2_rd_ptr)
  );

  assign w_unused_ep2 = ^{w_ep2_wr_ptr, w_ep2_rd_ptr};

  assign w_ep6_push = w_wr & ~w_ep6_full;
  assign w_ep6_pop  = host_rd_valid & host_rd_ready;

  fx2_sync_fifo #(
    .DW (DATA_W),
    .AW (AW)
  ) u_ep6 (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_ep6_push),
    .i_data    (fx2_db_in),
    .i_pop     (w_ep6_pop),
    .o_rd_data (w_ep6_data),
    .o_full    (w_ep6_full),
    .o_empty   (w_ep6_empty),
    .o_wr_ptr  (w_ep6_wr_ptr),
    .o_rd_ptr  (w_ep6_rd_ptr)
  );

  assign w_unc       = w_ep6_wr_ptr - r_commit_ptr;
  assign w_prev_addr = w_ep6_wr_ptr[AW-1:0] - PTR_ONE[AW-1:0];

  // A word pushed alongside PKTEND, or the one that fills a packet, closes the packet.
  always_comb begin
    w_commit_d      = r_commit_ptr;
    w_last_new      = 1'b0;
    w_set_last_prev = 1'b0;
    if (w_ep6_push) begin
      if (w_pktend || (w_unc == PKT_LAST)) begin
        w_commit_d = w_ep6_wr_ptr + PTR_ONE;
        w_last_new = 1'b1;
      end
    end else if (w_pktend && (w_unc != '0)) begin
      w_commit_d      = w_ep6_wr_ptr;
      w_set_last_prev = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_commit_ptr <= '0;
      r_last       <= '0;
      r_err        <= '0;
    end else begin
      r_commit_ptr <= w_commit_d;
      if (w_ep6_push) begin
        r_last[w_ep6_wr_ptr[AW-1:0]] <= w_last_new;
      end
      if (w_set_last_prev) begin
        r_last[w_prev_addr] <= 1'b1;
      end
      r_err.rd_empty <= w_rd & w_ep2_empty;
      r_err.wr_full  <= w_wr & w_ep6_full;
      r_err.addr     <= w_strobe_bad;
      r_err.conflict <= w_conflict;
    end
  end

  assign fx2_db_out    = w_ep2_data;
  assign fx2_db_oe     = w_oe & ~w_conflict;
  assign fx2_flaga     = ~w_ep2_empty;
  assign fx2_flagb     = ~w_ep6_full;
  assign fx2_flagc     = w_ep6_empty;
  assign fx2_flagd     = w_ep2_full;
  assign host_wr_ready = ~w_ep2_full;
  assign host_rd_valid = (w_ep6_rd_ptr != r_commit_ptr);
  assign host_rd_data  = w_ep6_data;
  assign host_rd_last  = host_rd_valid & r_last[w_ep6_rd_ptr[AW-1:0]];
  assign err_rd_empty  = r_err.rd_empty;
  assign err_wr_full   = r_err.wr_full;
  assign err_addr      = r_err.addr;
  assign err_conflict  = r_err.conflict;

endmodule

// File: tb/tb_fx2_slave_fifo_responder.sv
// Bench for the FX2 responder: two instances (PKT_WORDS 256 and 4) share stimulus and are
// checked every cycle against a queue-level model, plus literal spot checks.
module tb_fx2_slave_fifo_responder;

  localparam int DEPTH = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        slcs_n, slrd_n, slwr_n, sloe_n, pktend_n;
  logic [1:0]  a;
  logic [15:0] db_in;
  logic        host_wr_valid;
  logic [15:0] host_wr_data;
  logic        host_rd_ready;

  logic [15:0] db_out [2];
  logic        db_oe [2];
  logic        flaga [2];
  logic        flagb [2];
  logic        flagc [2];
  logic        flagd [2];
  logic        wr_ready [2];
  logic        rd_valid [2];
  logic [15:0] rd_data [2];
  logic        rd_last [2];
  logic        e_rde [2];
  logic        e_wrf [2];
  logic        e_adr [2];
  logic        e_cfl [2];

  fx2_slave_fifo_responder #(.DEPTH_LOG2(9), .PKT_WORDS(256)) u_dut0 (
    .clk (clk), .rst (rst),
    .fx2_slcs_n (slcs_n), .fx2_slrd_n (slrd_n), .fx2_slwr_n (slwr_n),
    .fx2_sloe_n (sloe_n), .fx2_pktend_n (pktend_n), .fx2_a (a),
    .fx2_db_in (db_in), .fx2_db_out (db_out[0]), .fx2_db_oe (db_oe[0]),
    .fx2_flaga (flaga[0]), .fx2_flagb (flagb[0]), .fx2_flagc (flagc[0]), .fx2_flagd (flagd[0]),
    .host_wr_valid (host_wr_valid), .host_wr_ready (wr_ready[0]), .host_wr_data (host_wr_data),
    .host_rd_valid (rd_valid[0]), .host_rd_ready (host_rd_ready),
    .host_rd_data (rd_data[0]), .host_rd_last (rd_last[0]),
    .err_rd_empty (e_rde[0]), .err_wr_full (e_wrf[0]),
    .err_addr (e_adr[0]), .err_conflict (e_cfl[0])
  );

  fx2_slave_fifo_responder #(.DEPTH_LOG2(9), .PKT_WORDS(4)) u_dut1 (
    .clk (clk), .rst (rst),
    .fx2_slcs_n (slcs_n), .fx2_slrd_n (slrd_n), .fx2_slwr_n (slwr_n),
    .fx2_sloe_n (sloe_n), .fx2_pktend_n (pktend_n), .fx2_a (a),
    .fx2_db_in (db_in), .fx2_db_out (db_out[1]), .fx2_db_oe (db_oe[1]),
    .fx2_flaga (flaga[1]), .fx2_flagb (flagb[1]), .fx2_flagc (flagc[1]), .fx2_flagd (flagd[1]),
    .host_wr_valid (host_wr_valid), .host_wr_ready (wr_ready[1]), .host_wr_data (host_wr_data),
    .host_rd_valid (rd_valid[1]), .host_rd_ready (host_rd_ready),
    .host_rd_data (rd_data[1]), .host_rd_last (rd_last[1]),
    .err_rd_empty (e_rde[1]), .err_wr_full (e_wrf[1]),
    .err_addr (e_adr[1]), .err_conflict (e_cfl[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d at %0t: got %h, expected %h", name, k, $time, act, exp);
    end
  endtask

  function automatic int pkt_of(input int k);
    return (k == 0) ? 256 : 4;
  endfunction

  // Model: EP2 as a word queue; EP6 as stored entries {last,data}, tail m_unc[k] uncommitted.
  logic [15:0] m_ep2 [$];
  logic [16:0] m_ep6 [2][$];
  int          m_unc [2];
  logic        m_started = 1'b0;
  logic        x_rde, x_adr, x_cfl;
  logic        x_wrf [2];

  always @(posedge clk) begin
    logic sel, rd, wr, pe, full;
    logic [16:0] ent;
    int sz;
    if (rst) begin
      m_ep2.delete();
      for (int k = 0; k < 2; k++) begin
        m_ep6[k].delete();
        m_unc[k] = 0;
        x_wrf[k] = 1'b0;
      end
      x_rde = 1'b0; x_adr = 1'b0; x_cfl = 1'b0;
      m_started = 1'b1;
    end else begin
      sel = !slcs_n;
      rd  = sel && !slrd_n && a == 2'b00;
      wr  = sel && !slwr_n && a == 2'b10;
      pe  = sel && !pktend_n && a == 2'b10;
      x_rde = rd && m_ep2.size() == 0;
      x_adr = sel && (a == 2'b01 || a == 2'b11) && (!slrd_n || !slwr_n || !pktend_n);
      x_cfl = sel && !sloe_n && !slwr_n;
      sz = m_ep2.size();
      if (rd && sz > 0) void'(m_ep2.pop_front());
      if (host_wr_valid && sz < DEPTH) m_ep2.push_back(host_wr_data);
      for (int k = 0; k < 2; k++) begin
        full = m_ep6[k].size() == DEPTH;
        x_wrf[k] = wr && full;
        if (host_rd_ready && (m_ep6[k].size() - m_unc[k]) > 0) void'(m_ep6[k].pop_front());
        if (wr && !full) begin
          m_ep6[k].push_back({1'b0, db_in});
          m_unc[k]++;
        end
        if (m_unc[k] > 0 && (pe || m_unc[k] == pkt_of(k))) begin
          sz = m_ep6[k].size();
          ent = m_ep6[k][sz-1];
          ent[16] = 1'b1;
          m_ep6[k][sz-1] = ent;
          m_unc[k] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      for (int k = 0; k < 2; k++) begin
        int ncom;
        ncom = m_ep6[k].size() - m_unc[k];
        chk("flaga", k, 32'(flaga[k]), 32'(m_ep2.size() != 0));
        chk("flagd", k, 32'(flagd[k]), 32'(m_ep2.size() == DEPTH));
        chk("wr_ready", k, 32'(wr_ready[k]), 32'(m_ep2.size() != DEPTH));
        chk("db_out", k, 32'(db_out[k]), (m_ep2.size() != 0) ? 32'(m_ep2[0]) : 32'd0);
        chk("db_oe", k, 32'(db_oe[k]), 32'(!slcs_n && !sloe_n && a == 2'b00 && slwr_n));
        chk("flagb", k, 32'(flagb[k]), 32'(m_ep6[k].size() != DEPTH));
        chk("flagc", k, 32'(flagc[k]), 32'(m_ep6[k].size() == 0));
        chk("rd_valid", k, 32'(rd_valid[k]), 32'(ncom > 0));
        if (ncom > 0) begin
          chk("rd_data", k, 32'(rd_data[k]), 32'(m_ep6[k][0][15:0]));
          chk("rd_last", k, 32'(rd_last[k]), 32'(m_ep6[k][0][16]));
        end else begin
          chk("rd_last", k, 32'(rd_last[k]), 32'd0);
        end
        chk("err_rd_empty", k, 32'(e_rde[k]), 32'(x_rde));
        chk("err_wr_full", k, 32'(e_wrf[k]), 32'(x_wrf[k]));
        chk("err_addr", k, 32'(e_adr[k]), 32'(x_adr));
        chk("err_conflict", k, 32'(e_cfl[k]), 32'(x_cfl));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pt();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_bus();
    slcs_n = 1'b1; slrd_n = 1'b1; slwr_n = 1'b1; sloe_n = 1'b1; pktend_n = 1'b1;
    a = 2'b00; db_in = 16'h0;
  endtask

  task automatic bus_wr(input logic [15:0] d);
    slcs_n = 1'b0; a = 2'b10; slwr_n = 1'b0; db_in = d;
    tick();
    idle_bus();
  endtask

  task automatic bus_pktend();
    slcs_n = 1'b0; a = 2'b10; pktend_n = 1'b0;
    tick();
    idle_bus();
  endtask

  task automatic host_push(input logic [15:0] d);
    host_wr_valid = 1'b1; host_wr_data = d;
    tick();
    host_wr_valid = 1'b0;
  endtask

  task automatic chk_reset_flags(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_flaga"}, k, 32'(flaga[k]), 32'd0);
      chk({tag, "_flagb"}, k, 32'(flagb[k]), 32'd1);
      chk({tag, "_flagc"}, k, 32'(flagc[k]), 32'd1);
      chk({tag, "_flagd"}, k, 32'(flagd[k]), 32'd0);
      chk({tag, "_rd_valid"}, k, 32'(rd_valid[k]), 32'd0);
      chk({tag, "_wr_ready"}, k, 32'(wr_ready[k]), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; idle_bus();
    host_wr_valid = 1'b0; host_wr_data = 16'h0; host_rd_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    pt();
    chk_reset_flags("reset");
    chk("reset_db_out", 0, 32'(db_out[0]), 32'd0);

    // EP2: host pushes four words, master reads them back.
    for (int i = 1; i <= 4; i++) host_push(16'(i));
    slcs_n = 1'b0; a = 2'b00; sloe_n = 1'b0; slrd_n = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      pt();
      chk("ep2_head", 0, 32'(db_out[0]), 32'(i));
      chk("ep2_oe", 0, 32'(db_oe[0]), 32'd1);
      tick();
    end
    idle_bus();
    pt();
    chk("ep2_flaga_fall", 0, 32'(flaga[0]), 32'd0);
    chk("ep2_no_err", 0, 32'(e_rde[0]), 32'd0);

    // EP6: eight words then PKTEND.
    for (int i = 0; i < 8; i++) bus_wr(16'hA000 + 16'(i));
    bus_pktend();
    host_rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pt();
      chk("pkt8_valid", 0, 32'(rd_valid[0]), 32'd1);
      chk("pkt8_data", 0, 32'(rd_data[0]), 32'h0000A000 + 32'(i));
      chk("pkt8_last", 0, 32'(rd_last[0]), 32'(i == 7));
      tick();
    end
    host_rd_ready = 1'b0;
    pt();
    chk("pkt8_flagc", 0, 32'(flagc[0]), 32'd1);

    // Auto-commit on the PKT_WORDS=4 instance.
    for (int i = 0; i < 6; i++) bus_wr(16'hB000 + 16'(i));
    host_rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pt();
      chk("auto_valid", 1, 32'(rd_valid[1]), 32'd1);
      chk("auto_data", 1, 32'(rd_data[1]), 32'h0000B000 + 32'(i));
      chk("auto_last", 1, 32'(rd_last[1]), 32'(i == 3));
      tick();
    end
    host_rd_ready = 1'b0;
    pt();
    chk("auto_held", 1, 32'(rd_valid[1]), 32'd0);
    chk("auto_held_flagc", 1, 32'(flagc[1]), 32'd0);
    chk("auto_dut0_held", 0, 32'(rd_valid[0]), 32'd0);
    bus_pktend();
    host_rd_ready = 1'b1;
    for (int i = 4; i < 6; i++) begin
      pt();
      chk("tail_data", 1, 32'(rd_data[1]), 32'h0000B000 + 32'(i));
      chk("tail_last", 1, 32'(rd_last[1]), 32'(i == 5));
      tick();
    end
    repeat (4) tick();
    host_rd_ready = 1'b0;
    pt();
    chk("drain_flagc", 0, 32'(flagc[0]), 32'd1);
    chk("drain_flagc", 1, 32'(flagc[1]), 32'd1);

    // Fill EP6, overflow, drain.
    for (int i = 0; i < DEPTH; i++) bus_wr(16'hC000 + 16'(i));
    pt();
    chk("fill_flagb", 0, 32'(flagb[0]), 32'd0);
    chk("fill_flagb", 1, 32'(flagb[1]), 32'd0);
    bus_wr(16'hDEAD);
    pt();
    chk("ovf_err", 0, 32'(e_wrf[0]), 32'd1);
    tick();
    pt();
    chk("ovf_err_clear", 0, 32'(e_wrf[0]), 32'd0);
    host_rd_ready = 1'b1;
    repeat (DEPTH) tick();
    host_rd_ready = 1'b0;
    pt();
    chk("ovf_not_stored", 0, 32'(flagc[0]), 32'd1);
    chk("ovf_not_stored", 1, 32'(flagc[1]), 32'd1);

    // EP2 read while empty.
    slcs_n = 1'b0; a = 2'b00; slrd_n = 1'b0;
    tick();
    idle_bus();
    pt();
    chk("rd_empty_err", 0, 32'(e_rde[0]), 32'd1);
    tick();
    pt();
    chk("rd_empty_clear", 0, 32'(e_rde[0]), 32'd0);
    host_push(16'h1234);
    pt();
    chk("rd_empty_ptr", 0, 32'(db_out[0]), 32'h00001234);
    slcs_n = 1'b0; a = 2'b00; slrd_n = 1'b0;
    tick();
    idle_bus();
    pt();
    chk("rd_empty_after", 0, 32'(flaga[0]), 32'd0);

    // Bad address, bus conflicts, empty PKTEND.
    slcs_n = 1'b0; a = 2'b01; slwr_n = 1'b0; db_in = 16'h5555;
    tick();
    idle_bus();
    pt();
    chk("bad_addr_err", 0, 32'(e_adr[0]), 32'd1);
    chk("bad_addr_nostore", 0, 32'(flagc[0]), 32'd1);
    slcs_n = 1'b0; a = 2'b10; sloe_n = 1'b0; slwr_n = 1'b0; db_in = 16'h6666;
    pt();
    chk("conflict_oe", 0, 32'(db_oe[0]), 32'd0);
    tick();
    idle_bus();
    pt();
    chk("conflict_err", 0, 32'(e_cfl[0]), 32'd1);
    chk("conflict_wr", 0, 32'(flagc[0]), 32'd0);
    slcs_n = 1'b0; a = 2'b00; sloe_n = 1'b0; slwr_n = 1'b0;
    pt();
    chk("conflict_oe_ep2", 0, 32'(db_oe[0]), 32'd0);
    tick();
    idle_bus();
    pt();
    chk("conflict_err_ep2", 0, 32'(e_cfl[0]), 32'd1);
    bus_pktend();
    pt();
    chk("conflict_pkt_data", 0, 32'(rd_data[0]), 32'h00006666);
    host_rd_ready = 1'b1;
    repeat (2) tick();
    host_rd_ready = 1'b0;
    bus_pktend();
    pt();
    chk("empty_pktend_valid", 0, 32'(rd_valid[0]), 32'd0);
    chk("empty_pktend_flagc", 0, 32'(flagc[0]), 32'd1);

    // Reset mid-packet.
    for (int i = 0; i < 3; i++) bus_wr(16'hD000 + 16'(i));
    host_push(16'hE000);
    host_push(16'hE001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pt();
    chk_reset_flags("midrst");
    repeat (3) tick();
    pt();
    chk("midrst_valid_held", 0, 32'(rd_valid[0]), 32'd0);
    chk("midrst_valid_held", 1, 32'(rd_valid[1]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
